// File: rtl/bp_fe_realigner_if.sv
// Fetch-window in / aligned-instruction out bundle between I$ return and PC-gen IF2 scan.
interface bp_fe_realigner_if #(parameter int vaddr_width_p = 39);
  logic                     redirect_v_i;
  logic                     fetch_v_i;
  logic [vaddr_width_p-1:0] fetch_pc_i;
  logic [31:0]              fetch_data_i;
  logic                     fetch_yumi_o;
  logic                     fetch_instr_v_o;
  logic                     fetch_instr_ready_i;
  logic [31:0]              fetch_instr_o;
  logic [vaddr_width_p-1:0] fetch_instr_pc_o;
  logic                     fetch_linear_o;
  logic                     fetch_catchup_o;
  logic                     fetch_rebase_o;

  modport slave (
    input  redirect_v_i, fetch_v_i, fetch_pc_i, fetch_data_i, fetch_instr_ready_i,
    output fetch_yumi_o, fetch_instr_v_o, fetch_instr_o, fetch_instr_pc_o,
           fetch_linear_o, fetch_catchup_o, fetch_rebase_o
  );

  modport master (
    output redirect_v_i, fetch_v_i, fetch_pc_i, fetch_data_i, fetch_instr_ready_i,
    input  fetch_yumi_o, fetch_instr_v_o, fetch_instr_o, fetch_instr_pc_o,
           fetch_linear_o, fetch_catchup_o, fetch_rebase_o
  );
endinterface

// File: rtl/bp_fe_realigner.sv
// Realigns 4-byte fetch windows into one RV64IC instruction per cycle, zero-cycle combinational path.
// Window is consumed only when the produced instruction is accepted; state is frozen while ready is low.
module bp_fe_realigner #(
  parameter int vaddr_width_p = 39
) (
  input  logic             clk_i,
  input  logic             reset_i,
  bp_fe_realigner_if.slave bus
);
  localparam int va = vaddr_width_p;

  logic          resid_v_r, resid_v_n;
  logic [15:0]   resid_r, resid_n;
  logic [va-1:0] resid_pc_r, resid_pc_n;
  logic          hold_v_r, hold_v_n;
  logic [15:0]   hold_r, hold_n;
  logic [va-1:0] hold_pc_r, hold_pc_n;

  logic [15:0]   lo, hi;
  logic          lo_c, hi_c, match;
  logic [va-1:0] win_pc, mid_pc, resid_next_pc;

  logic          instr_v, yumi, linear, catchup, rebase;
  logic          split, drop;
  logic [31:0]   instr;
  logic [va-1:0] instr_pc;

  assign lo            = bus.fetch_data_i[15:0];
  assign hi            = bus.fetch_data_i[31:16];
  assign lo_c          = (lo[1:0] != 2'b11);
  assign hi_c          = (hi[1:0] != 2'b11);
  assign win_pc        = {bus.fetch_pc_i[va-1:2], 2'b00};
  assign mid_pc        = win_pc + va'(2);
  assign resid_next_pc = resid_pc_r + va'(2);
  assign match         = (bus.fetch_pc_i == resid_next_pc);

  always_comb begin
    instr_v    = 1'b0;
    instr      = '0;
    instr_pc   = '0;
    yumi       = 1'b0;
    linear     = 1'b0;
    catchup    = 1'b0;
    rebase     = 1'b0;
    split      = 1'b0;
    drop       = 1'b0;
    resid_v_n  = resid_v_r;
    resid_n    = resid_r;
    resid_pc_n = resid_pc_r;
    hold_v_n   = hold_v_r;
    hold_n     = hold_r;
    hold_pc_n  = hold_pc_r;

    if (bus.redirect_v_i) begin
      resid_v_n = 1'b0;
      hold_v_n  = 1'b0;
    end else if (hold_v_r) begin
      instr_v  = 1'b1;
      instr    = {16'h0, hold_r};
      instr_pc = hold_pc_r;
      catchup  = 1'b1;
      if (bus.fetch_instr_ready_i) hold_v_n = 1'b0;
    end else if (bus.fetch_v_i) begin
      if (resid_v_r && match) begin
        instr_v  = 1'b1;
        instr    = {lo, resid_r};
        instr_pc = resid_pc_r;
        split    = 1'b1;
      end else begin
        // A non-sequential window invalidates the residual; process it as fresh.
        drop = resid_v_r;
        if (!bus.fetch_pc_i[1]) begin
          instr_v  = 1'b1;
          instr_pc = bus.fetch_pc_i;
          if (lo_c) begin
            instr = {16'h0, lo};
            split = 1'b1;
          end else begin
            instr = bus.fetch_data_i;
          end
        end else if (hi_c) begin
          instr_v  = 1'b1;
          instr    = {16'h0, hi};
          instr_pc = bus.fetch_pc_i;
        end else begin
          linear     = 1'b1;
          yumi       = 1'b1;
          resid_v_n  = 1'b1;
          resid_n    = hi;
          resid_pc_n = bus.fetch_pc_i;
        end
      end

      if (split && !hi_c) linear = 1'b1;

      if (instr_v) begin
        yumi   = bus.fetch_instr_ready_i;
        rebase = drop & bus.fetch_instr_ready_i;
        if (bus.fetch_instr_ready_i) begin
          resid_v_n = 1'b0;
          if (split && hi_c) begin
            hold_v_n  = 1'b1;
            hold_n    = hi;
            hold_pc_n = mid_pc;
          end else if (split) begin
            resid_v_n  = 1'b1;
            resid_n    = hi;
            resid_pc_n = mid_pc;
          end
        end
      end else begin
        rebase = drop;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      resid_v_r  <= 1'b0;
      resid_r    <= '0;
      resid_pc_r <= '0;
      hold_v_r   <= 1'b0;
      hold_r     <= '0;
      hold_pc_r  <= '0;
    end else begin
      resid_v_r  <= resid_v_n;
      resid_r    <= resid_n;
      resid_pc_r <= resid_pc_n;
      hold_v_r   <= hold_v_n;
      hold_r     <= hold_n;
      hold_pc_r  <= hold_pc_n;
    end
  end

  assign bus.fetch_instr_v_o  = instr_v;
  assign bus.fetch_instr_o    = instr;
  assign bus.fetch_instr_pc_o = instr_pc;
  assign bus.fetch_yumi_o     = yumi;
  assign bus.fetch_linear_o   = linear;
  assign bus.fetch_catchup_o  = catchup;
  assign bus.fetch_rebase_o   = rebase;

  illegal_odd_pc_a: assert property (@(posedge clk_i) disable iff (!reset_i)
    bus.fetch_v_i |-> !bus.fetch_pc_i[0]);

endmodule

// File: tb/tb_bp_fe_realigner.sv
// Scoreboard bench for bp_fe_realigner: expectations queued at drive time, popped at the sample edge.
module tb_bp_fe_realigner;
  localparam int VA = 39;
  localparam logic [VA-1:0] TOP = 39'h7F_FFFF_FFFE;

  typedef struct {
    logic          v;
    logic [31:0]   instr;
    logic [VA-1:0] pc;
    logic          lin;
    logic          cu;
    logic          rb;
    logic          yumi;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bp_fe_realigner_if #(.vaddr_width_p(VA)) bus ();

  bp_fe_realigner #(.vaddr_width_p(VA)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [31:0] i, input logic [VA-1:0] p,
                              input logic lin, input logic cu, input logic rb, input logic y);
    exp_t e;
    e.v = v; e.instr = i; e.pc = p; e.lin = lin; e.cu = cu; e.rb = rb; e.yumi = y;
    return e;
  endfunction

  task automatic apply(input string tag, input logic rd, input logic fv, input logic [VA-1:0] pc,
                       input logic [31:0] d, input logic rdy, input exp_t e);
    exp_t x;
    bus.redirect_v_i        = rd;
    bus.fetch_v_i           = fv;
    bus.fetch_pc_i          = pc;
    bus.fetch_data_i        = d;
    bus.fetch_instr_ready_i = rdy;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    chk({tag, ".v"}, 64'(bus.fetch_instr_v_o), 64'(x.v));
    if (x.v) begin
      chk({tag, ".instr"}, 64'(bus.fetch_instr_o), 64'(x.instr));
      chk({tag, ".pc"}, 64'(bus.fetch_instr_pc_o), 64'(x.pc));
    end
    chk({tag, ".linear"}, 64'(bus.fetch_linear_o), 64'(x.lin));
    chk({tag, ".catchup"}, 64'(bus.fetch_catchup_o), 64'(x.cu));
    chk({tag, ".rebase"}, 64'(bus.fetch_rebase_o), 64'(x.rb));
    chk({tag, ".yumi"}, 64'(bus.fetch_yumi_o), 64'(x.yumi));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic rdy);
    apply(tag, 1'b0, 1'b0, '0, '0, rdy, mk(0, 0, 0, 0, 0, 0, 0));
  endtask

  // Leaves residual {0x0013, 0x3002} after emitting c-instr 0x4501 at 0x3000.
  task automatic load_resid(input string tag);
    apply(tag, 0, 1, 39'h3000, 32'h0013_4501, 1, mk(1, 32'h4501, 39'h3000, 1, 0, 0, 1));
  endtask

  initial begin
    bus.redirect_v_i = 0; bus.fetch_v_i = 0; bus.fetch_pc_i = '0;
    bus.fetch_data_i = '0; bus.fetch_instr_ready_i = 0;

    idle("in_reset", 1);
    rst_n = 1'b1;
    idle("post_reset", 1);

    // Two compressed in one window, hold then released.
    apply("two_c0", 0, 1, 39'h2000, 32'h4001_4501, 1, mk(1, 32'h4501, 39'h2000, 0, 0, 0, 1));
    apply("two_c1", 0, 0, '0, '0, 1, mk(1, 32'h4001, 39'h2002, 0, 1, 0, 0));
    idle("two_c_done", 1);

    // Straddle across windows.
    load_resid("strad0");
    apply("strad1", 0, 1, 39'h3004, 32'h4501_0000, 1, mk(1, 32'h0000_0013, 39'h3002, 0, 0, 0, 1));
    apply("strad2", 0, 0, '0, '0, 1, mk(1, 32'h4501, 39'h3006, 0, 1, 0, 0));

    // Rebase on non-sequential window.
    load_resid("rb0");
    apply("rb1", 0, 1, 39'h5000, 32'h0000_0013, 1, mk(1, 32'h13, 39'h5000, 0, 0, 1, 1));
    idle("rb_done", 1);

    // Mismatch under backpressure keeps the residual.
    load_resid("rbbp0");
    apply("rbbp1", 0, 1, 39'h5000, 32'h0000_0013, 0, mk(1, 32'h13, 39'h5000, 0, 0, 0, 0));
    apply("rbbp2", 0, 1, 39'h3004, 32'h4501_0000, 1, mk(1, 32'h13, 39'h3002, 0, 0, 0, 1));
    apply("rbbp3", 0, 0, '0, '0, 1, mk(1, 32'h4501, 39'h3006, 0, 1, 0, 0));

    // Backpressure for three cycles, then redirect clears residual.
    load_resid("bp0");
    for (int i = 0; i < 3; i++)
      apply($sformatf("bp_stall%0d", i), 0, 1, 39'h3004, 32'h4501_0000, 0,
            mk(1, 32'h13, 39'h3002, 0, 0, 0, 0));
    apply("bp_redir", 1, 1, 39'h3004, 32'h4501_0000, 1, mk(0, 0, 0, 0, 0, 0, 0));
    apply("bp_after0", 0, 1, 39'h3004, 32'h4501_0000, 1, mk(1, 32'h0, 39'h3004, 0, 0, 0, 1));
    apply("bp_after1", 0, 0, '0, '0, 1, mk(1, 32'h4501, 39'h3006, 0, 1, 0, 0));

    // Redirect flushes a stalled catch-up.
    apply("hflush0", 0, 1, 39'h2000, 32'h4001_4501, 1, mk(1, 32'h4501, 39'h2000, 0, 0, 0, 1));
    apply("hflush1", 0, 1, 39'h9000, 32'h0000_0013, 0, mk(1, 32'h4001, 39'h2002, 0, 1, 0, 0));
    apply("hflush_redir", 1, 0, '0, '0, 1, mk(0, 0, 0, 0, 0, 0, 0));
    idle("hflush_done", 1);

    // High-half entry, compressed.
    apply("hi_c", 0, 1, 39'h6002, 32'h4501_FFFF, 1, mk(1, 32'h4501, 39'h6002, 0, 0, 0, 1));

    // Reset mid-operation with a live residual.
    load_resid("mrst0");
    rst_n = 1'b0;
    idle("mrst_in", 1);
    rst_n = 1'b1;
    apply("mrst1", 0, 1, 39'h1000, 32'h0000_0013, 1, mk(1, 32'h13, 39'h1000, 0, 0, 0, 1));

    // High-half entry with full instruction, sequential across address wrap.
    apply("wrap0", 0, 1, TOP, 32'h0513_0000, 1, mk(0, 0, 0, 1, 0, 0, 1));
    apply("wrap1", 0, 1, '0, 32'h0001_00A0, 1, mk(1, 32'h00A0_0513, TOP, 0, 0, 0, 1));
    apply("wrap2", 0, 0, '0, '0, 1, mk(1, 32'h0001, 39'h2, 0, 1, 0, 0));
    idle("wrap_done", 1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
